// File: rtl/ispm_loader_pkg.sv
// Shared types and constants for the ISPM image loader.
package ispm_loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/ispm_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid marks the 4th byte.
import ispm_loader_pkg::*;

module ispm_word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] lane;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            lane <= '0;
            word <= '0;
        end else if (byte_valid) begin
            lane <= lane + 2'd1;
            // Shifting in from the top leaves the first byte in the low lane.
            word <= {byte_data, word[31:8]};
        end
    end

    assign word_valid = byte_valid && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ispm_loader.sv
// Byte-stream to ISPM bus loader; holds the core in reset until the image is written.
// Optional trailing XOR checksum enabled by ISPM_LOADER_CHECKSUM_EN.
import ispm_loader_pkg::*;

module ispm_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] io_bus_addr,
    output logic                  io_bus_write,
    output logic [31:0]           io_bus_data_in,
    input  logic                  io_bus_ready,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    state_t state, next_state;
    logic        take;
    logic        word_valid;
    logic        do_restart;
    logic [7:0]  len_lo;
    logic [15:0] remaining;

    assign take       = in_valid && in_ready;
    assign do_restart = (state == DONE) && restart;

    ispm_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (do_restart),
        .byte_valid (take && (state == DATA)),
        .byte_data  (in_data),
        .word       (io_bus_data_in),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= LEN0;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LEN0:  if (take) next_state = LEN1;
            LEN1:  if (take) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
                       next_state = ({in_data, len_lo} == 16'd0) ? CSUM : DATA;
`else
                       next_state = ({in_data, len_lo} == 16'd0) ? DONE : DATA;
`endif
                   end
            DATA:  if (word_valid) next_state = WRITE;
            WRITE: if (io_bus_ready) begin
`ifdef ISPM_LOADER_CHECKSUM_EN
                       next_state = (remaining == 16'd1) ? CSUM : DATA;
`else
                       next_state = (remaining == 16'd1) ? DONE : DATA;
`endif
                   end
            CSUM:  if (take) next_state = DONE;
            DONE:  if (restart) next_state = LEN0;
            default: next_state = LEN0;
        endcase
    end

    always_comb begin
        in_ready     = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
        io_bus_write = (state == WRITE);
        done         = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_lo      <= '0;
            remaining   <= '0;
            io_bus_addr <= ADDR_WIDTH'(BASE_ADDR);
        end else begin
            if (state == LEN0 && take) len_lo <= in_data;
            if (state == LEN1 && take) remaining <= {in_data, len_lo};
            if (state == WRITE && io_bus_ready) begin
                // Address wraps naturally at 2^ADDR_WIDTH for oversized images.
                io_bus_addr <= io_bus_addr + ADDR_WIDTH'(1);
                remaining   <= remaining - 16'd1;
            end
            if (do_restart) io_bus_addr <= ADDR_WIDTH'(BASE_ADDR);
        end
    end

`ifdef ISPM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csum  <= '0;
            error <= 1'b0;
        end else begin
            if (state == DATA && take) csum <= csum ^ in_data;
            if (state == CSUM && take) error <= (in_data != csum);
            if (do_restart) begin
                csum  <= '0;
                error <= 1'b0;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

    assign core_reset = !done || error;

endmodule

// File: tb/tb_ispm_loader.sv
// Directed scoreboard bench for ispm_loader; covers the checksum path when ISPM_LOADER_CHECKSUM_EN is defined.
module tb_ispm_loader;

    localparam int unsigned AW   = 12;
    localparam int unsigned BASE = 0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          restart = 1'b0;
    logic [AW-1:0] io_bus_addr;
    logic          io_bus_write;
    logic [31:0]   io_bus_data_in;
    logic          io_bus_ready = 1'b1;
    logic          core_reset;
    logic          done;
    logic          error;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         expq[$];
    int          holds[$];
    logic [31:0] img[$];
    int          hold_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    ispm_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .restart        (restart),
        .io_bus_addr    (io_bus_addr),
        .io_bus_write   (io_bus_write),
        .io_bus_data_in (io_bus_data_in),
        .io_bus_ready   (io_bus_ready),
        .core_reset     (core_reset),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write-side scoreboard: every cycle the write is up, addr/data must match the queue head.
    always @(negedge clk) begin
        #1;
        if (reset_n && io_bus_write) begin
            hold_cnt++;
            chk("in_ready_during_write", 32'(in_ready), 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'(io_bus_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(io_bus_addr), expq[0].a);
                chk("wr_data", io_bus_data_in, expq[0].d);
                if (io_bus_ready) void'(expq.pop_front());
            end
            if (io_bus_ready) begin
                holds.push_back(hold_cnt);
                hold_cnt = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] csum_tweak);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        int          t;
        wr_t         e;
        x = '0;
        n = 16'(img.size());
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < img.size(); i++) begin
            w   = img[i];
            e.a = (BASE + i) % (1 << AW);
            e.d = w;
            expq.push_back(e);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[7:0]);
                x = x ^ w[7:0];
                w = w >> 8;
            end
        end
`ifdef ISPM_LOADER_CHECKSUM_EN
        send_byte(x ^ csum_tweak);
`else
        x = csum_tweak;
`endif
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_after_image", 32'(done), 32'd1);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_write", 32'(io_bus_write), 32'd0);
        chk("rst_addr", 32'(io_bus_addr), 32'(BASE));
        chk("rst_data", io_bus_data_in, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Two words, bus always ready.
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        holds.delete();
        send_image(8'h00);
        chk("t1_core_reset", 32'(core_reset), 32'd0);
        chk("t1_hold", 32'(holds[0]), 32'd1);

        // Same image with the first write stalled for 3 cycles.
        pulse_restart();
        chk("restart_core_reset", 32'(core_reset), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_addr", 32'(io_bus_addr), 32'(BASE));
        holds.delete();
        io_bus_ready = 1'b0;
        fork
            begin
                int t;
                t = 0;
                while (!io_bus_write && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(negedge clk);
                io_bus_ready = 1'b1;
            end
        join_none
        send_image(8'h00);
        chk("t2_hold_first", 32'(holds[0]), 32'd4);
        chk("t2_hold_second", 32'(holds[1]), 32'd1);
        chk("t2_core_reset", 32'(core_reset), 32'd0);

        // Zero-length image.
        pulse_restart();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef ISPM_LOADER_CHECKSUM_EN
        chk("zero_len_csum_state", 32'(done), 32'd0);
        send_byte(8'h00);
`endif
        chk("zero_len_done", 32'(done), 32'd1);
        chk("zero_len_holds", 32'(holds.size()), 32'd2);

`ifdef ISPM_LOADER_CHECKSUM_EN
        pulse_restart();
        img = '{32'h0804_0201};
        send_image(8'h00);
        chk("csum_ok_error", 32'(error), 32'd0);
        chk("csum_ok_core_reset", 32'(core_reset), 32'd0);
        pulse_restart();
        send_image(8'h01);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_core_reset", 32'(core_reset), 32'd1);
        pulse_restart();
        chk("csum_restart_error", 32'(error), 32'd0);
        chk("csum_restart_core_reset", 32'(core_reset), 32'd1);
        chk("csum_restart_in_ready", 32'(in_ready), 32'd1);
`endif

        // Reset mid-word aborts without any write.
        pulse_restart();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_write", 32'(io_bus_write), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_addr", 32'(io_bus_addr), 32'(BASE));
        repeat (4) @(negedge clk);
        img = '{32'h4433_2211};
        send_image(8'h00);
        chk("midrst_core_reset", 32'(core_reset), 32'd0);

        // Oversized image wraps the address.
        pulse_restart();
        img.delete();
        for (int i = 0; i < 4097; i++) img.push_back((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000);
        send_image(8'h00);
        chk("wrap_final_addr", 32'(io_bus_addr), 32'(BASE + 1));
        chk("wrap_core_reset", 32'(core_reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        chk("global_timeout", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "FAIL global_timeout observed=running expected=finished");
    end

endmodule

// File: doc/ispm_loader.md
# ispm_loader

Bus-side initiator that fills the instruction scratchpad before the core runs. It accepts a byte stream (typically from the UART receiver), assembles little-endian 32-bit words, and issues one write per word on the scratchpad's `io_bus_*` port. It holds the core in reset until the whole image is written. It sits between the host link and the ISPM bus port, at the opposite end of that port from the scratchpad.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: scratchpad word-address width (4096 words).
- `BASE_ADDR`, 0: first word address written.

Ports:
- `clk`  in  1: sole clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: byte available.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts byte; transfer on `in_valid && in_ready`.
- `restart`  in  1: single-cycle pulse; in DONE, starts a new load.
- `io_bus_addr`  out  ADDR_WIDTH: word address.
- `io_bus_write`  out  1: write request.
- `io_bus_data_in`  out  32: write data.
- `io_bus_ready`  in  1: scratchpad accepts write this cycle.
- `core_reset`  out  1: holds the core in reset; high during the load.
- `done`  out  1: image fully written.
- `error`  out  1: checksum mismatch (sticky until restart or reset).

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes, each word least-significant byte first. With the checksum feature enabled, one trailing XOR byte follows.
- States and transitions:
  - LEN0: take LEN_LO, go to LEN1.
  - LEN1: take LEN_HI. If N==0, go to CSUM or DONE. Otherwise go to DATA.
  - DATA: take bytes into lanes 0..3. After lane 3, go to WRITE.
  - WRITE: hold `io_bus_write=1` with stable addr and data until `io_bus_ready`. On accept, increment addr, decrement remaining, and go to DATA, or to CSUM/DONE when remaining==0.
  - CSUM: take one byte and compare.
  - DONE: wait for `restart`.
- `in_ready` is 1 in LEN0, LEN1, DATA and CSUM. It is 0 in WRITE and DONE.
- Word address is `BASE_ADDR` plus the word index, modulo 2^ADDR_WIDTH. With N > 4096, later words overwrite earlier ones from address 0.
- Outputs:
  - `core_reset = !done || error`.
  - `done` is 1 only in DONE.
- `restart` in DONE:
  - Clears `error`.
  - Resets the address to `BASE_ADDR`.
  - Goes to LEN0, so `core_reset` reasserts the next cycle.
- `restart` in any other state is ignored.

## Timing
- Reset values:
  - State LEN0.
  - `in_ready=1`, `io_bus_write=0`, `io_bus_addr=BASE_ADDR`, `io_bus_data_in=0`.
  - `core_reset=1`, `done=0`, `error=0`.
- `reset_n` low mid-load aborts the load immediately. No partial word is written after reset.
- Latency:
  - `io_bus_write` rises the cycle after the 4th byte of a word is accepted.
  - A write accepted in the same cycle it is raised costs 1 cycle.
  - Throughput is at most one word per 5 cycles.
- `io_bus_addr` and `io_bus_data_in` are stable while `io_bus_write=1`. `io_bus_write` deasserts the cycle after acceptance.
- `done` rises the cycle after the final write is accepted, or the cycle after the checksum byte is accepted.
- `in_valid` while `in_ready=0` is ignored. The source must hold the byte.

## Configuration
- `ISPM_LOADER_CHECKSUM_EN` defined:
  - A running XOR covers all data bytes (not the length bytes) and is cleared on reset and on restart.
  - The CSUM state accepts the trailing byte. A mismatch sets `error`.
  - DONE is entered either way. `core_reset` stays high when `error=1`.
- Macro undefined:
  - No CSUM state; the final write goes directly to DONE.
  - `error` is tied to 0, and the stream carries no trailing byte.

## Structure
- Shared package `ispm_loader_pkg` holds:
  - The state enum: LEN0, LEN1, DATA, WRITE, CSUM, DONE.
  - Constants `BYTES_PER_WORD=4` and `LEN_BYTES=2`.
- One natural sub-module, `ispm_word_packer`: byte-lane counter plus a 32-bit shift register. It raises `word_valid` after 4 bytes and is cleared on its `clear` input.
- The FSM, address counter, remaining-count counter and checksum stay in `ispm_loader`.

## Test plan
- Load N=2, bytes `78 56 34 12 EF BE AD DE`, `io_bus_ready` always 1 -> writes `0x12345678` at 0 and `0xDEADBEEF` at 1; `done=1`, `core_reset=0`.
- Same stream, `io_bus_ready` low for 3 cycles on the first write -> `io_bus_write` held 4 cycles with stable addr/data; `in_ready=0` throughout; final memory identical.
- Length bytes `00 00` -> no bus write; `done` asserted the cycle after LEN_HI (or after the checksum byte `00` when the feature is enabled).
- With `ISPM_LOADER_CHECKSUM_EN`, N=1, data `01 02 04 08`:
  - checksum `0F` -> `error=0`;
  - checksum `0E` -> `error=1` and `core_reset=1`;
  - then `restart` -> `error=0`, `core_reset=1`, state LEN0.
- `reset_n` low for 1 cycle after 2 data bytes of word 0 -> no bus write; a fresh N=1 stream writes address 0 correctly.
- N=4097 with `io_bus_ready=1` -> last word written at address 0; `done=1`.
